// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life controller.
package gol_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned CELLS = ROWS * COLS;

  typedef logic [CELLS-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    EXTINCT = 2'd1,
    STABLE  = 2'd2,
    LIMIT   = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/gol_controller_gen_timer.sv
// Interval down-counter: load sets the count, dec walks it toward zero.
module gen_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] value_i,
  output logic         expire_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/gol_controller.sv
// Generation register, run/step control and halt detection for the Life engine.
module gol_controller
  import gol_pkg::*;
#(
  parameter int unsigned       ROWS    = gol_pkg::ROWS,
  parameter int unsigned       COLS    = gol_pkg::COLS,
  parameter int unsigned       GEN_W   = 16,
  parameter logic [GEN_W-1:0]  MAX_GEN = 16'hFFFF,
  parameter int unsigned       IVL_W   = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   seed_valid,
  input  logic [ROWS*COLS-1:0]   seed_data,
  output logic                   seed_ready,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic [IVL_W-1:0]       interval,
  input  logic [ROWS*COLS-1:0]   grid_evolve,
  output logic [ROWS*COLS-1:0]   grid,
  output logic [GEN_W-1:0]       gen_count,
  output logic                   gen_valid,
  output logic                   running,
  output logic                   halted,
  output logic [1:0]             halt_cause
);

  localparam int unsigned NCELL = ROWS * COLS;

  ctrl_state_t        state_q, state_d;
  halt_cause_t        cause_q, cause_d;
  logic [NCELL-1:0]   grid_q, grid_d;
  logic [GEN_W-1:0]   gen_q, gen_d, gen_inc;
  logic               gv_q, gv_d;
  logic               seed_acc;
  logic               timer_load, timer_dec, timer_expire;

  gen_timer #(.W(IVL_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (timer_load),
    .dec_i    (timer_dec),
    .value_i  (interval),
    .expire_c (timer_expire)
  );

  // Generation counter saturates at MAX_GEN rather than wrapping.
  assign gen_inc  = (gen_q >= MAX_GEN) ? gen_q : gen_q + GEN_W'(1);
  assign seed_acc = seed_valid && (state_q != RUN);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    grid_d     = grid_q;
    gen_d      = gen_q;
    gv_d       = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    if (seed_acc) begin
      grid_d  = seed_data;
      gen_d   = '0;
      cause_d = NONE;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (grid_q == '0) begin
              state_d = HALT;
              cause_d = EXTINCT;
            end else begin
              state_d    = RUN;
              timer_load = 1'b1;
            end
          end else if (step) begin
            grid_d = grid_evolve;
            gen_d  = gen_inc;
            gv_d   = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (!timer_expire) begin
            timer_dec = 1'b1;
          end else begin
            grid_d     = grid_evolve;
            gen_d      = gen_inc;
            gv_d       = 1'b1;
            timer_load = 1'b1;
            // Final generation is committed even when it triggers a halt.
            if (grid_evolve == '0) begin
              state_d = HALT;
              cause_d = EXTINCT;
            end else if (grid_evolve == grid_q) begin
              state_d = HALT;
              cause_d = STABLE;
            end else if (gen_inc == MAX_GEN) begin
              state_d = HALT;
              cause_d = LIMIT;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cause_q <= NONE;
      grid_q  <= '0;
      gen_q   <= '0;
      gv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      grid_q  <= grid_d;
      gen_q   <= gen_d;
      gv_q    <= gv_d;
    end
  end

  assign seed_ready = (state_q != RUN);
  assign running    = (state_q == RUN);
  assign halted     = (state_q == HALT);
  assign halt_cause = 2'(cause_q);
  assign grid       = grid_q;
  assign gen_count  = gen_q;
  assign gen_valid  = gv_q;

endmodule

// File: tb/tb_gol_controller.sv
// Randomized and directed bench for gol_controller against a Life reference model.
module tb_gol_controller;

  localparam int unsigned NR      = 8;
  localparam int unsigned NC      = 8;
  localparam int          MAXG    = 150;
  localparam int          S_IDLE  = 0;
  localparam int          S_RUN   = 1;
  localparam int          S_HALT  = 2;

  localparam logic [63:0] BLINK   = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        seed_valid = 1'b0;
  logic [63:0] seed_data = '0;
  logic        seed_ready;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic [23:0] interval = '0;
  logic [63:0] grid_evolve;
  logic [63:0] grid;
  logic [15:0] gen_count;
  logic        gen_valid;
  logic        running;
  logic        halted;
  logic [1:0]  halt_cause;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] m_grid;
  int          m_gen, m_st, m_cause, m_timer;
  bit          m_gv;

  gol_controller #(.MAX_GEN(16'(MAXG))) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seed_valid  (seed_valid),
    .seed_data   (seed_data),
    .seed_ready  (seed_ready),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .interval    (interval),
    .grid_evolve (grid_evolve),
    .grid        (grid),
    .gen_count   (gen_count),
    .gen_valid   (gen_valid),
    .running     (running),
    .halted      (halted),
    .halt_cause  (halt_cause)
  );

  always #5 clk = ~clk;

  // Conway's rule on a bounded grid (cells outside are dead).
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < int'(NR); r++) begin
      for (int c = 0; c < int'(NC); c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < int'(NR) &&
                c + dc >= 0 && c + dc < int'(NC)) begin
              cnt += int'(g[(r + dr) * int'(NC) + c + dc]);
            end
          end
        end
        n[r * int'(NC) + c] = (cnt == 3) || (g[r * int'(NC) + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  always_comb grid_evolve = life(grid);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grid = '0; m_gen = 0; m_st = S_IDLE; m_cause = 0; m_timer = 0; m_gv = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".grid"}, grid, m_grid);
    check({tag, ".gen_count"}, 64'(gen_count), 64'(m_gen));
    check({tag, ".gen_valid"}, 64'(gen_valid), 64'(m_gv));
    check({tag, ".status"}, 64'({running, halted, halt_cause, seed_ready}),
          64'({m_st == S_RUN, m_st == S_HALT, 2'(m_cause), m_st != S_RUN}));
  endtask

  // Advance one clock: predict from the pre-edge inputs, then compare after the edge.
  task automatic tick(input string tag);
    logic [63:0] ng, ev;
    int          ngen, nst, ncause, ntim;
    bit          ngv;
    ng = m_grid; ngen = m_gen; nst = m_st; ncause = m_cause; ntim = m_timer; ngv = 1'b0;
    if (m_st != S_RUN && seed_valid) begin
      ng = seed_data; ngen = 0; ncause = 0; nst = S_IDLE;
    end else if (m_st == S_IDLE) begin
      if (start) begin
        if (m_grid == '0) begin nst = S_HALT; ncause = 1; end
        else begin nst = S_RUN; ntim = int'(interval); end
      end else if (step) begin
        ng = life(m_grid); ngen = (m_gen >= MAXG) ? MAXG : m_gen + 1; ngv = 1'b1;
      end
    end else if (m_st == S_RUN) begin
      if (stop) nst = S_IDLE;
      else if (m_timer != 0) ntim = m_timer - 1;
      else begin
        ev = life(m_grid);
        ng = ev; ngen = (m_gen >= MAXG) ? MAXG : m_gen + 1; ngv = 1'b1; ntim = int'(interval);
        if (ev == '0) begin nst = S_HALT; ncause = 1; end
        else if (ev == m_grid) begin nst = S_HALT; ncause = 2; end
        else if (m_gen + 1 >= MAXG) begin nst = S_HALT; ncause = 3; end
      end
    end
    @(posedge clk);
    #1;
    m_grid = ng; m_gen = ngen; m_st = nst; m_cause = ncause; m_timer = ntim; m_gv = ngv;
    check_all(tag);
  endtask

  task automatic load_seed(input logic [63:0] s);
    seed_valid = 1'b1; seed_data = s; start = 1'b0; stop = 1'b0; step = 1'b0;
    tick("seed");
    seed_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #11;
    check_all("reset");
    @(negedge clk) reset_n = 1'b1;

    // Blinker at interval 0
    load_seed(BLINK);
    interval = '0; start = 1'b1;
    tick("blink_start");
    start = 1'b0;
    tick("blink_g1");
    check("blink_g1_const", grid, BLINK_H);
    tick("blink_g2");
    check("blink_g2_const", grid, BLINK);
    for (int i = 0; i < 98; i++) tick("blink_run");
    check("blink_100_gen", 64'(gen_count), 64'd100);
    check("blink_100_run", 64'({running, halted, gen_valid}), 64'b101);
    seed_valid = 1'b1; seed_data = BLOCK;
    tick("seed_in_run");
    check("seed_ready_run", 64'(seed_ready), 64'd0);
    seed_valid = 1'b0; stop = 1'b1;
    tick("blink_stop");
    stop = 1'b0;

    // Block still life
    load_seed(BLOCK);
    start = 1'b1;
    tick("block_start");
    start = 1'b0;
    tick("block_commit");
    check("block_halt", 64'({halted, halt_cause, gen_count}), 64'({1'b1, 2'd2, 16'd1}));
    check("block_grid", grid, BLOCK);
    start = 1'b1; step = 1'b1;
    tick("halt_ignores");
    start = 1'b0; step = 1'b0;

    // Single cell dies, then start on an empty grid
    load_seed(SINGLE);
    start = 1'b1;
    tick("single_start");
    start = 1'b0;
    tick("single_commit");
    check("single_ext", 64'({grid == '0, halt_cause, gen_count}), 64'({1'b1, 2'd1, 16'd1}));
    load_seed('0);
    start = 1'b1;
    tick("empty_start");
    start = 1'b0;
    check("empty_ext", 64'({halted, halt_cause, gen_count}), 64'({1'b1, 2'd1, 16'd0}));

    // Cadence at interval 4, then stop on the would-be commit cycle
    load_seed(BLINK);
    interval = 24'd4; start = 1'b1;
    tick("cad_start");
    start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick("cad_run");
      if (k == 4)  check("cad_k4",  64'(gen_count), 64'd0);
      if (k == 5)  check("cad_k5",  64'(gen_count), 64'd1);
      if (k == 10) check("cad_k10", 64'(gen_count), 64'd2);
      if (k == 15) check("cad_k15", 64'(gen_count), 64'd3);
    end
    stop = 1'b1;
    tick("cad_stop");
    stop = 1'b0;
    check("cad_stop_state", 64'({running, gen_valid, gen_count}), 64'({1'b0, 1'b0, 16'd3}));

    // Single steps and seed/start collision
    load_seed(BLINK);
    step = 1'b1;
    for (int i = 0; i < 3; i++) tick("step");
    step = 1'b0;
    check("step3", 64'({running, halted, gen_count}), 64'({2'b00, 16'd3}));
    seed_valid = 1'b1; seed_data = BLOCK; start = 1'b1;
    tick("seed_vs_start");
    seed_valid = 1'b0; start = 1'b0;
    check("seed_vs_start_c", 64'({running, gen_count}), 64'({1'b0, 16'd0}));

    // Generation limit
    load_seed(BLINK);
    interval = '0; start = 1'b1;
    tick("lim_start");
    start = 1'b0;
    for (int i = 0; i < 400 && !halted; i++) tick("lim_run");
    check("limit", 64'({halted, halt_cause, gen_count}), 64'({1'b1, 2'd3, 16'(MAXG)}));

    // Asynchronous reset mid-run
    load_seed(BLINK);
    start = 1'b1;
    tick("rst_start");
    start = 1'b0;
    tick("rst_run");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk) reset_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      seed_valid = ($urandom_range(15) == 0);
      seed_data  = (i % 3 == 0) ? BLINK : {$urandom, $urandom} & {$urandom, $urandom};
      start      = ($urandom_range(7) == 0);
      stop       = ($urandom_range(15) == 0);
      step       = ($urandom_range(7) == 0);
      if ($urandom_range(31) == 0) interval = 24'($urandom_range(3));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gol_controller.md
Name: gol_controller

Overview:
Sequential control and state stage for the Game of Life engine.
- Holds the current generation in a register and drives it to the combinational evolve datapath.
- Commits the datapath's next generation on a programmable cadence.
- Accepts seed patterns over a valid/ready handshake, supports run/stop/single-step, counts generations and halts automatically on extinction, still life or generation limit.

Parameters:
ROWS, 8, grid height in cells
COLS, 8, grid width in cells
GEN_W, 16, generation counter width
MAX_GEN, 16'hFFFF, generation count that forces LIMIT halt
IVL_W, 24, interval counter width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
seed_valid  in  1  seed pattern offered
seed_data  in  ROWS*COLS  seed pattern; bit r*COLS+c = cell (row r, col c)
seed_ready  out  1  seed accepted this cycle when high with seed_valid
start  in  1  enter RUN (level sampled per cycle)
stop  in  1  leave RUN
step  in  1  single-generation request while IDLE
interval  in  IVL_W  cycles between generations minus one
grid_evolve  in  ROWS*COLS  next generation from evolve datapath
grid  out  ROWS*COLS  current generation, to evolve datapath and display
gen_count  out  GEN_W  generations committed since last seed
gen_valid  out  1  one-cycle pulse after each commit
running  out  1  state == RUN
halted  out  1  state == HALT
halt_cause  out  2  NONE=0, EXTINCT=1, STABLE=2, LIMIT=3

Behaviour:
- Reset (async assert, sync deassert): grid=0, gen_count=0, gen_valid=0, state IDLE, halt_cause NONE, timer=0. seed_ready=1, running=0, halted=0. Reset mid-RUN aborts immediately, no commit.
- States: IDLE, RUN, HALT. seed_ready = state!=RUN (combinational).
- Seed accept (IDLE or HALT, seed_valid&seed_ready): grid<=seed_data, gen_count<=0, halt_cause<=NONE, state<=IDLE. Seed accept beats start and step in the same cycle.
- IDLE, start=1, no seed accept:
  - grid==0 -> HALT, cause EXTINCT.
  - Otherwise -> RUN, timer<=interval.
- IDLE, step=1, start=0:
  - Commit one generation at that edge: grid<=grid_evolve, gen_count+1, gen_valid next cycle.
  - Stay IDLE. Halt checks are not applied.
- RUN, stop=1 -> IDLE at that edge. No commit that cycle, even if timer==0.
- RUN, timer!=0: timer decrements.
- RUN, timer==0 (commit):
  - grid<=grid_evolve, gen_count<=gen_count+1, timer<=interval (resampled), gen_valid=1 in the following cycle.
  - Throughput: one generation per interval+1 cycles; interval=0 gives a commit every cycle.
- Halt checks, evaluated on the commit edge (RUN only), priority EXTINCT > STABLE > LIMIT:
  - grid_evolve==0 -> HALT, EXTINCT.
  - grid_evolve==grid -> HALT, STABLE.
  - gen_count+1==MAX_GEN -> HALT, LIMIT.
  - A still life commits one final, identical generation; gen_count includes it.
- HALT: grid, gen_count and halt_cause frozen. start, stop and step ignored. Exit only via seed accept or reset.
- gen_count never wraps. The IDLE step path saturates at MAX_GEN without halting.
- start and stop both high in RUN: stop wins. Both high in IDLE: start acts, stop ignored.
- grid_evolve is treated as combinational from grid: no extra latency stage.

Decomposition:
- Package gol_pkg:
  - Constants: ROWS, COLS, CELLS=ROWS*COLS.
  - typedef grid_t (logic [CELLS-1:0]).
  - enum ctrl_state_t {IDLE, RUN, HALT}.
  - enum halt_cause_t {NONE, EXTINCT, STABLE, LIMIT}, 2-bit.
- Sub-module gen_timer: interval down-counter.
  - Inputs: load, value.
  - Outputs: expire (timer==0), running decrement.
- The evolve datapath is instantiated beside this block at top level; it is not inside it.

Test Plan:
- Blinker, 8x8: seed 64'h0000_0008_0808_0000, interval=0, start.
  - Gen 1 grid=64'h0000_0000_1C00_0000; gen 2 returns to seed.
  - gen_valid pulses every cycle; no halt after 100 generations.
- Block still life: seed 64'h0000_0018_1800_0000, start.
  - After 1 commit: halted=1, halt_cause=2, gen_count=1, grid unchanged.
- Single cell: seed 64'h0000_0000_0800_0000, start.
  - First commit: grid=0, halt_cause=1, gen_count=1.
  - start with grid==0 in IDLE -> HALT EXTINCT, gen_count=0.
- Cadence: blinker, interval=4, start at cycle T.
  - Commits at T+5, T+10, T+15.
  - Raise stop in the cycle timer==0: no commit; running=0; gen_count holds.
- Step/handshake:
  - In IDLE, pulse step 3 times on blinker -> gen_count=3, state IDLE.
  - seed_valid during RUN -> seed_ready=0, grid unaffected.
  - Seed plus start in the same IDLE cycle -> seed taken, stays IDLE.
- Reset/limit:
  - Assert reset_n=0 mid-RUN -> all outputs at reset values immediately.
  - Build with MAX_GEN=5 on blinker -> HALT LIMIT with gen_count=5.
